// File: rtl/kernel_distributor_scheduler_pkg.sv
// Shared types and helpers for the kernel-buffer-to-PE distribution scheduler.
// The control word layout is {trc, bank}, with the bank select in the low bits.
package kernel_distributor_scheduler_pkg;

    localparam int KD_DEPTH = 2;
    localparam int CTRL_W   = 2 * KD_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } kdist_state_t;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic [KD_DEPTH-1:0] trc,
        input logic [KD_DEPTH-1:0] bank
    );
        return {trc, bank};
    endfunction

endpackage

// File: rtl/kdist_beat_counter.sv
// Nested beat counter: the bank index runs 0..trc as the inner loop and the
// word address is the outer loop. o_last flags the final (addr, bank) pair.
module kdist_beat_counter #(
    parameter int D      = 4,
    parameter int ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_step,
    input  logic [$clog2(D)-1:0]   i_trc,
    input  logic [ADDR_W:0]        i_words,
    output logic [ADDR_W-1:0]      o_addr,
    output logic [$clog2(D)-1:0]   o_bank,
    output logic                   o_last
);

    localparam int BW = $clog2(D);

    logic [ADDR_W-1:0] r_addr;
    logic [BW-1:0]     r_bank;
    logic              w_bank_wrap;
    logic [ADDR_W:0]   w_words_m1;

    // One bit wider than the address so a full 2^ADDR_W tile terminates on
    // the last address instead of comparing against a wrapped zero.
    assign w_words_m1  = i_words - (ADDR_W + 1)'(1);
    assign w_bank_wrap = (r_bank == i_trc);
    assign o_last      = w_bank_wrap && ({1'b0, r_addr} == w_words_m1);
    assign o_addr      = r_addr;
    assign o_bank      = r_bank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_bank <= '0;
        end else if (i_clear) begin
            r_addr <= '0;
            r_bank <= '0;
        end else if (i_step) begin
            if (w_bank_wrap) begin
                r_bank <= '0;
                r_addr <= r_addr + ADDR_W'(1);
            end else begin
                r_bank <= r_bank + BW'(1);
            end
        end
    end

endmodule

// File: rtl/kernel_distributor_scheduler.sv
// Issues kernel-buffer reads and the matching {Trc, bankSelect} word one cycle
// later, with a valid/ready output stage that stalls reads under backpressure.
module kernel_distributor_scheduler
    import kernel_distributor_scheduler_pkg::*;
#(
    parameter int depth  = KD_DEPTH,
    parameter int D      = 1 << depth,
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [depth-1:0]     cfg_trc,
    input  logic [ADDR_W:0]      cfg_num_words,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_rd_en,
    output logic [ADDR_W-1:0]    buf_rd_addr,
    output logic [2*depth-1:0]   control_signal,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    kdist_state_t           r_state;
    logic [depth-1:0]       r_trc_q;
    logic [ADDR_W:0]        r_words_q;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [$clog2(D)-1:0]   r_bank_stage;

    logic                   w_issue_ok;
    logic                   w_issue;
    logic                   w_clear;
    logic                   w_final_hs;
    logic [ADDR_W-1:0]      w_addr;
    logic [$clog2(D)-1:0]   w_bank;
    logic                   w_last;

    assign w_issue_ok = !r_out_valid || out_ready;
    assign w_issue    = (r_state == ST_RUN) && w_issue_ok;
    assign w_clear    = (r_state == ST_IDLE) && start;
    assign w_final_hs = r_out_valid && out_ready && r_out_last;

    kdist_beat_counter #(
        .D      (D),
        .ADDR_W (ADDR_W)
    ) u_beat_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_step  (w_issue),
        .i_trc   (r_trc_q),
        .i_words (r_words_q),
        .o_addr  (w_addr),
        .o_bank  (w_bank),
        .o_last  (w_last)
    );

    // Sequencer: done is registered, so it appears the cycle after FIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_trc_q   <= '0;
            r_words_q <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_trc_q   <= cfg_trc;
                        r_words_q <= cfg_num_words;
                        r_busy    <= 1'b1;
                        r_state   <= (cfg_num_words == '0) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_issue && w_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_final_hs) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output stage p0: follows the buffer's 1-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_bank_stage <= '0;
        end else if (w_issue) begin
            r_out_valid  <= 1'b1;
            r_out_last   <= w_last;
            r_bank_stage <= w_bank;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign buf_rd_en      = w_issue;
    assign buf_rd_addr    = w_addr;
    assign control_signal = pack_ctrl(r_trc_q, r_bank_stage);
    assign out_valid      = r_out_valid;
    assign out_last       = r_out_last;

endmodule

// File: doc/kernel_distributor_scheduler.md
Name: kernel_distributor_scheduler

Overview:
- Sequences the kernel-buffer-to-PE distribution path. Issues read addresses to the kernel buffer and drives the distributor's `{Trc, bankSelect}` control word.
- Both are aligned with the buffer's 1-cycle read latency, so every emitted beat carries the matching control word.
- One `start` triggers one tile. `done` pulses at the end of the tile.
- Output side uses a valid/ready handshake towards the PE array and stalls the buffer reads under backpressure.

Parameters:
- `depth`, 2, log2 of the bank count.
- `D`, `1<<depth`, number of kernel buffer banks / distributor rows.
- `ADDR_W`, 10, kernel buffer address width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; latches config; ignored while `busy`.
- `cfg_trc`  in  depth  group size minus 1 (0..D-1).
- `cfg_num_words`  in  ADDR_W+1  kernel words per tile (0..2^ADDR_W).
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  1-cycle pulse after the last beat handshakes.
- `buf_rd_en`  out  1  kernel buffer read strobe.
- `buf_rd_addr`  out  ADDR_W  kernel buffer read address.
- `control_signal`  out  2*depth  `{Trc, bankSelect}` to the distributor, aligned with buffer read data.
- `out_valid`  out  1  distributor output is a valid beat.
- `out_ready`  in  1  PE array accepts the beat.
- `out_last`  out  1  marks the final beat of the tile.

Behaviour:
- Reset (async, `reset`=1): all outputs are 0; FSM goes to IDLE; counters are 0.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: on `start`, latch `trc_q`=`cfg_trc` and `words_q`=`cfg_num_words`. Clear `addr_cnt` and `bank_cnt`.
    - If `words_q`==0, go to FIN.
    - Otherwise go to RUN.
  - RUN: issue one read per cycle when `issue_ok` = !`out_valid` | `out_ready`.
    - Each issue: `buf_rd_en`=1 and `buf_rd_addr`=`addr_cnt`. Stage register captures `bank_cnt` and last-flag.
    - Counter order: bank inner, address outer. `bank_cnt` runs 0..`trc_q` and wraps to 0 while `addr_cnt` increments.
    - Total beats = `words_q`*(`trc_q`+1).
    - After issuing the final `(addr, bank)` pair, go to DRAIN.
  - DRAIN: wait until the final beat handshakes (`out_valid` & `out_ready` & `out_last`), then go to FIN.
  - FIN: assert `done` for 1 cycle, then go to IDLE. `busy` is 0 in IDLE and in the cycle after FIN.
- Latency: beat data is valid exactly 1 cycle after its `buf_rd_en`.
  - `out_valid`, `out_last` and `control_signal` are registered on an issue and show up with the data.
  - `control_signal` = `{trc_q, bank_stage}`.
- Backpressure: when `out_valid` & !`out_ready`:
  - no issue occurs, so `buf_rd_en`=0;
  - `control_signal`, `out_valid` and `out_last` hold.
  - The kernel buffer is required to hold its read data while `buf_rd_en`=0.
- `out_valid` falls the cycle after a handshake with no new issue.
- `start` while `busy` is ignored. Config changes mid-tile have no effect.
- `cfg_trc` values for which D is not divisible by `cfg_trc`+1 are passed through unchanged. The distributor's behaviour for those rows is outside this block's contract.
- Reset asserted mid-tile aborts immediately. No `done` is produced, and `out_valid` is 0 on the cycle reset is seen.
- `cfg_num_words`=2^ADDR_W: `addr_cnt` reaches 2^ADDR_W-1 and terminates without wrap. Use an ADDR_W+1 comparison.
- `start` in the same cycle as FIN is ignored; accepted only in IDLE.

Decomposition:
- Shared package: `kdist_state_t` enum (IDLE/RUN/DRAIN/FIN), `CTRL_W` = 2*depth, and a control-word pack function `{trc, bank}`.
- One sub-module is natural: `kdist_beat_counter`, the nested bank/address counter with wrap and a last-flag output.
- The handshake stage stays inline.

Test Plan:
- `cfg_trc`=1, `cfg_num_words`=3, `out_ready`=1 constant:
  - 6 beats on consecutive cycles;
  - `buf_rd_addr` sequence 0,0,1,1,2,2;
  - `control_signal` sequence 0x4,0x5,0x4,0x5,0x4,0x5 (depth=2);
  - `out_last` on beat 6;
  - `done` 2 cycles after the last handshake... FIN one cycle after the last handshake.
- `cfg_trc`=3, `cfg_num_words`=2, `out_ready` toggled 1,0,0,1,...:
  - no `buf_rd_en` while stalled;
  - `control_signal` and `out_valid` hold;
  - 8 beats in total;
  - banks 0..3 per address.
- `cfg_num_words`=0: `start` -> no `buf_rd_en`, no `out_valid`; `done` pulses 2 cycles after `start`.
- `start` pulsed again mid-tile with a different `cfg_trc`: ignored; the original sequence completes unchanged.
- `reset` asserted on beat 3 of a 6-beat tile: all outputs 0 asynchronously; a fresh `start` afterwards runs the full 6 beats from addr 0.
- `cfg_trc`=0, `cfg_num_words`=1024, `out_ready`=1: 1024 beats; last address 1023; `control_signal` bank field always 0; exactly one `done`.
